// File: rtl/pipeline_sequencer_if.sv
// Hazard/flush request inputs and pipeline-register control outputs of the sequencer.
// The master modport drives the requests; the slave (the sequencer) drives the controls.
interface pipeline_sequencer_if;
   logic       load_use_in;
   logic       mcu_start_in;
   logic       mcu_done_in;
   logic       bru_flush_in;
   logic       jump_flush_in;
   logic       pc_enable_out;
   logic [3:0] stage_enable_out;
   logic [3:0] stage_flush_out;
   logic [1:0] state_out;
   logic       mcu_timeout_out;

   modport master (
      output load_use_in,
      output mcu_start_in,
      output mcu_done_in,
      output bru_flush_in,
      output jump_flush_in,
      input  pc_enable_out,
      input  stage_enable_out,
      input  stage_flush_out,
      input  state_out,
      input  mcu_timeout_out
   );

   modport slave (
      input  load_use_in,
      input  mcu_start_in,
      input  mcu_done_in,
      input  bru_flush_in,
      input  jump_flush_in,
      output pc_enable_out,
      output stage_enable_out,
      output stage_flush_out,
      output state_out,
      output mcu_timeout_out
   );
endinterface

// File: rtl/pipeline_sequencer.sv
// Pipeline controller for Core101: boot hold-off, load-use bubbles, multi-cycle unit freezes
// with timeout, and branch/jump flushes. Mealy outputs from registered state and live inputs.
module pipeline_sequencer #(
   parameter int unsigned BOOT_CYCLES = 4,
   parameter int unsigned MCU_TIMEOUT = 64
) (
   input logic               clock_in,
   input logic               reset_in,
   pipeline_sequencer_if.slave seq
);

   localparam int unsigned BootW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam int unsigned TmoW  = $clog2(MCU_TIMEOUT);

   localparam logic [BootW-1:0] BootInit = BootW'(BOOT_CYCLES - 1);
   localparam logic [TmoW-1:0]  TmoLast  = TmoW'(MCU_TIMEOUT - 1);

   // Enable/flush patterns, bit order IF/ID, ID/EX, EX/MEM, MEM/WB.
   localparam logic [3:0] EnAll    = 4'b1111;
   localparam logic [3:0] EnMcu    = 4'b0011;
   localparam logic [3:0] EnLdUse  = 4'b0111;
   localparam logic [3:0] FlNone   = 4'b0000;
   localparam logic [3:0] FlAll    = 4'b1111;
   localparam logic [3:0] FlBru    = 4'b1100;
   localparam logic [3:0] FlJump   = 4'b1000;
   localparam logic [3:0] FlMcu    = 4'b0010;
   localparam logic [3:0] FlLdUse  = 4'b0100;

   typedef enum logic [1:0] {
      StBoot    = 2'b00,
      StRun     = 2'b01,
      StWaitMcu = 2'b10
   } state_e;

   state_e           state_q, state_d;
   logic [BootW-1:0] boot_cnt_q, boot_cnt_d;
   logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic             tmo_flag_q, tmo_flag_d;

   logic       pc_en;
   logic [3:0] stage_en;
   logic [3:0] stage_fl;

   always_comb begin
      state_d    = state_q;
      boot_cnt_d = boot_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      tmo_flag_d = tmo_flag_q;
      pc_en      = 1'b0;
      stage_en   = 4'b0000;
      stage_fl   = FlAll;

      case (state_q)
         StBoot: begin
            if (boot_cnt_q == '0) begin
               state_d = StRun;
            end else begin
               boot_cnt_d = boot_cnt_q - 1'b1;
            end
         end

         StRun: begin
            pc_en    = 1'b1;
            stage_en = EnAll;
            stage_fl = FlNone;
            if (seq.bru_flush_in) begin
               stage_fl = FlBru;
            end else if (seq.jump_flush_in) begin
               stage_fl = FlJump;
            end else if (seq.mcu_start_in && !seq.mcu_done_in) begin
               pc_en     = 1'b0;
               stage_en  = EnMcu;
               stage_fl  = FlMcu;
               tmo_cnt_d = '0;
               state_d   = StWaitMcu;
            end else if (seq.mcu_start_in) begin
               // Single-cycle op: done arrives with start, run normally.
               stage_fl = FlNone;
            end else if (seq.load_use_in) begin
               pc_en    = 1'b0;
               stage_en = EnLdUse;
               stage_fl = FlLdUse;
            end
         end

         StWaitMcu: begin
            if (tmo_cnt_q != TmoLast) begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
            if (seq.mcu_done_in || (tmo_cnt_q == TmoLast)) begin
               pc_en    = 1'b1;
               stage_en = EnAll;
               stage_fl = FlNone;
               state_d  = StRun;
               if (!seq.mcu_done_in) begin
                  tmo_flag_d = 1'b1;
               end
            end else begin
               pc_en    = 1'b0;
               stage_en = EnMcu;
               stage_fl = FlMcu;
            end
         end

         // Encoding 11 is unreachable; hold the boot pattern and recover into RUN.
         default: begin
            state_d = StRun;
         end
      endcase
   end

   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) begin
         state_q    <= StBoot;
         boot_cnt_q <= BootInit;
         tmo_cnt_q  <= '0;
         tmo_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         tmo_flag_q <= tmo_flag_d;
      end
   end

   assign seq.pc_enable_out    = pc_en;
   assign seq.stage_enable_out = stage_en;
   assign seq.stage_flush_out  = stage_fl;
   assign seq.state_out        = state_q;
   assign seq.mcu_timeout_out  = tmo_flag_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: a cycle-level behavioural model checked every cycle,
// plus hand-computed literal expectations at key points of the sequence.
module tb_pipeline_sequencer;

   localparam int unsigned Boot = 4;
   localparam int unsigned Tmo  = 8;

   logic clk;
   logic reset_in;
   int   total = 0;
   int   bad   = 0;
   bit   chk_en = 1'b0;

   pipeline_sequencer_if sq ();

   pipeline_sequencer #(
      .BOOT_CYCLES (Boot),
      .MCU_TIMEOUT (Tmo)
   ) dut (
      .clock_in (clk),
      .reset_in (reset_in),
      .seq      (sq.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: boot cycles still to go, whether waiting on the multi-cycle unit,
   // how many WAIT cycles already elapsed, and the sticky timeout.
   int boot_left = Boot;
   bit in_wait   = 1'b0;
   int wait_idx  = 0;
   bit sticky    = 1'b0;

   always @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         boot_left <= Boot;
         in_wait   <= 1'b0;
         wait_idx  <= 0;
         sticky    <= 1'b0;
      end else if (boot_left > 0) begin
         boot_left <= boot_left - 1;
      end else if (in_wait) begin
         if (sq.mcu_done_in) begin
            in_wait <= 1'b0;
         end else if (wait_idx == Tmo - 1) begin
            in_wait <= 1'b0;
            sticky  <= 1'b1;
         end else begin
            wait_idx <= wait_idx + 1;
         end
      end else if (!sq.bru_flush_in && !sq.jump_flush_in && sq.mcu_start_in && !sq.mcu_done_in) begin
         in_wait  <= 1'b1;
         wait_idx <= 0;
      end
   end

   // {timeout, pc_en, enable[3:0], flush[3:0], state[1:0]}
   function automatic logic [11:0] model_vec();
      logic [3:0] en, fl;
      logic       pc;
      logic [1:0] st;
      if (!reset_in || boot_left > 0) begin
         pc = 1'b0; en = 4'b0000; fl = 4'b1111; st = 2'b00;
      end else if (in_wait) begin
         st = 2'b10;
         if (sq.mcu_done_in || wait_idx == Tmo - 1) begin
            pc = 1'b1; en = 4'b1111; fl = 4'b0000;
         end else begin
            pc = 1'b0; en = 4'b0011; fl = 4'b0010;
         end
      end else begin
         st = 2'b01;
         pc = 1'b1; en = 4'b1111; fl = 4'b0000;
         if (sq.bru_flush_in) fl = 4'b1100;
         else if (sq.jump_flush_in) fl = 4'b1000;
         else if (sq.mcu_start_in && !sq.mcu_done_in) begin
            pc = 1'b0; en = 4'b0011; fl = 4'b0010;
         end else if (sq.mcu_start_in) fl = 4'b0000;
         else if (sq.load_use_in) begin
            pc = 1'b0; en = 4'b0111; fl = 4'b0100;
         end
      end
      return {sticky && reset_in, pc, en, fl, st};
   endfunction

   function automatic logic [11:0] dut_vec();
      return {sq.mcu_timeout_out, sq.pc_enable_out, sq.stage_enable_out,
              sq.stage_flush_out, sq.state_out};
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++;
            $display("FAIL model_cmp t=%0t got=%b want=%b", $time, dut_vec(), model_vec());
         end
      end
   end

   task automatic check_lit(input string name, input logic [11:0] want);
      total++;
      if (dut_vec() !== want) begin
         bad++;
         $display("FAIL %s t=%0t got=%b want=%b", name, $time, dut_vec(), want);
      end
   endtask

   // Apply inputs just after a rising edge, return at the following falling edge.
   task automatic cyc(input logic lu, input logic st, input logic dn, input logic bru,
                      input logic jmp);
      @(posedge clk);
      #1;
      sq.load_use_in   = lu;
      sq.mcu_start_in  = st;
      sq.mcu_done_in   = dn;
      sq.bru_flush_in  = bru;
      sq.jump_flush_in = jmp;
      @(negedge clk);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   localparam logic [11:0] VBoot   = 12'b0_0_0000_1111_00;
   localparam logic [11:0] VRun    = 12'b0_1_1111_0000_01;
   localparam logic [11:0] VLdUse  = 12'b0_0_0111_0100_01;
   localparam logic [11:0] VStart  = 12'b0_0_0011_0010_01;
   localparam logic [11:0] VStall  = 12'b0_0_0011_0010_10;
   localparam logic [11:0] VRel    = 12'b0_1_1111_0000_10;

   task automatic boot_seq(input string tag);
      @(posedge clk);
      #1;
      reset_in = 1'b1;
      @(negedge clk);
      check_lit({tag, "_boot1"}, VBoot);
      for (int i = 2; i <= Boot; i++) begin
         idle();
         check_lit({tag, "_bootn"}, VBoot);
      end
      idle();
      check_lit({tag, "_run1"}, VRun);
   endtask

   initial begin
      reset_in         = 1'b0;
      sq.load_use_in   = 1'b0;
      sq.mcu_start_in  = 1'b0;
      sq.mcu_done_in   = 1'b0;
      sq.bru_flush_in  = 1'b0;
      sq.jump_flush_in = 1'b0;
      chk_en           = 1'b1;
      repeat (2) @(negedge clk);
      check_lit("reset", VBoot);

      boot_seq("a");

      // Load-use bubble lasts one cycle.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_lit("load_use", VLdUse);
      idle();
      check_lit("after_load_use", VRun);

      // Multi-cycle op with done three cycles after start.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_lit("mcu_start", VStart);
      idle();
      check_lit("mcu_wait1", VStall);
      idle();
      check_lit("mcu_wait2", VStall);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_lit("mcu_done", VRel);
      idle();
      check_lit("mcu_after", VRun);

      // Start and done together: no stall.
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      check_lit("mcu_single", VRun);
      idle();
      check_lit("mcu_single_after", VRun);

      // Flush priority.
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      check_lit("bru_prio", 12'b0_1_1111_1100_01);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check_lit("jump_prio", 12'b0_1_1111_1000_01);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      check_lit("bru_over_start", 12'b0_1_1111_1100_01);

      // Timeout: flush inputs ignored while waiting, release on the 8th WAIT cycle.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_lit("tmo_start", VStart);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      check_lit("wait_flush_ignored", VStall);
      for (int i = 2; i <= Tmo - 1; i++) begin
         idle();
         check_lit("tmo_stall", VStall);
      end
      idle();
      check_lit("tmo_release", VRel);
      idle();
      check_lit("tmo_flag_set", 12'b1_1_1111_0000_01);
      repeat (3) idle();
      check_lit("tmo_flag_held", 12'b1_1_1111_0000_01);

      // Asynchronous reset in the middle of a WAIT.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();
      check_lit("pre_async", 12'b1_0_0011_0010_10);
      @(posedge clk);
      #3;
      reset_in = 1'b0;
      #1;
      check_lit("async_reset", VBoot);
      @(negedge clk);
      boot_seq("b");
      idle();
      check_lit("b_run2", VRun);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
      $fatal(1);
   end

endmodule
